// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the device clock, deserializes
// 11-bit frames and decodes E0/F0 prefixes into key events. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_keyboard_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_data_out,
    output logic       key_strobe,
    output logic       key_extended,
    output logic       key_break,
    output logic       frame_error
);

    localparam int unsigned CODE_W   = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CODE_W-1:0] CODE_EXT = 8'hE0;
    localparam logic [CODE_W-1:0] CODE_BRK = 8'hF0;
    localparam logic [CNT_W-1:0]  CNT_PAR  = 4'd8;
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK,
        S_DECODE
    } state_t;

    // Reset: asserts asynchronously, releases two clocks after the pin goes high
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Two-flop synchronizers; PS/2 lines idle high
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       data_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign data_s = data_sync[1];

    // Filtered clock only flips after FILTER_LEN identical samples
    logic [FILTER_LEN-1:0] filt_sh;
    logic                  filt_q;
    logic                  fall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_sh <= '1;
            filt_q  <= 1'b1;
        end else begin
            filt_sh <= {filt_sh[FILTER_LEN-2:0], clk_sync[1]};
            if (&filt_sh)       filt_q <= 1'b1;
            else if (~|filt_sh) filt_q <= 1'b0;
        end
    end

    assign fall_c = filt_q & ~|filt_sh;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic              stop_q, stop_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              ext_pend_q, ext_pend_d;
    logic              brk_pend_q, brk_pend_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              strobe_q, strobe_d;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic              err_q, err_d;
    logic              frame_ok_c;
`ifdef PS2_PARITY_CHECK_EN
    logic              parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            stop_q     <= 1'b0;
            to_cnt_q   <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_q     <= '0;
            strobe_q   <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            stop_q     <= stop_d;
            to_cnt_q   <= to_cnt_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            code_q     <= code_d;
            strobe_q   <= strobe_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Event outputs are loaded on the CHECK exit, so they are visible during DECODE
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_d     = stop_q;
        to_cnt_d   = to_cnt_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        code_d     = code_q;
        strobe_d   = 1'b0;
        ext_d      = 1'b0;
        brk_d      = 1'b0;
        err_d      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d   = parity_q;
        frame_ok_c = stop_q & (^{shift_q, parity_q});
`else
        frame_ok_c = stop_q;
`endif

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (fall_c && !data_s) begin
                    state_d   = S_RECV;
                    bit_cnt_d = '0;
                end
            end
            S_RECV: begin
                if (fall_c) begin
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < CNT_PAR) begin
                        shift_d = {data_s, shift_q[CODE_W-1:1]};
                    end else if (bit_cnt_q == CNT_PAR) begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_d = data_s;
`endif
                    end else begin
                        stop_d  = data_s;
                        state_d = S_CHECK;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!frame_ok_c) begin
                    err_d      = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end else begin
                    state_d = S_DECODE;
                    if (shift_q == CODE_EXT) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == CODE_BRK) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        strobe_d   = 1'b1;
                        ext_d      = ext_pend_q;
                        brk_d      = brk_pend_q;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                        if (!brk_pend_q)            code_d = shift_q;
                        else if (shift_q == code_q) code_d = '0;
                    end
                end
            end
            S_DECODE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign ps2_data_out = code_q;
    assign key_strobe   = strobe_q;
    assign key_extended = ext_q;
    assign key_break    = brk_q;
    assign frame_error  = err_q;

endmodule

// File: doc/ps2_keyboard_receiver.md
Name: ps2_keyboard_receiver

Overview:
Receives the PS/2 keyboard serial stream (device-driven ps2_clk/ps2_data) and deserializes 11-bit frames into 8-bit scan codes. Decodes make, break (F0) and extended (E0) prefixes. Presents a level-held ps2_data_out code to the game-logic/menu FSM plus a one-cycle strobe per completed key event. Sits between the board PS/2 pins and the snake game logic.

Parameters:
FILTER_LEN, 8, number of consecutive identical clk samples required to accept a new ps2_clk level (glitch filter)
TIMEOUT_CYCLES, 200000, idle clk cycles mid-frame before the frame is abandoned (2 ms at 100 MHz)

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset (block in reset while reset==0)
ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous
ps2_data  input  1  raw PS/2 data from keyboard, asynchronous
ps2_data_out  output  8  currently held make code; 8'h00 when no key held
key_strobe  output  1  one-cycle pulse on every accepted make or break event
key_extended  output  1  1 if the event on key_strobe carried an E0 prefix
key_break  output  1  1 if the event on key_strobe was a release (F0)
frame_error  output  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, ps2_data_out=8'h00, FSM IDLE, prefix flags cleared, bit counter 0.
- Inputs pass a 2-flop synchronizer; ps2_clk then passes a FILTER_LEN-sample filter. Falling edge of filtered ps2_clk = sample point; ps2_data sampled (synchronized) on that cycle.
- Frame: start(0), D0..D7 LSB first, odd parity, stop(1).
- FSM IDLE: on falling edge with data==0 -> RECV, bit counter=0. Falling edge with data==1 ignored (no error).
- RECV: shift 8 data bits, then parity, then stop; counter 0..9. After stop bit -> CHECK.
- CHECK (1 cycle): valid iff stop==1 and (PS2_PARITY_CHECK_EN) ones(D)+parity odd. Invalid -> frame_error pulse, prefix flags cleared, -> IDLE. Valid -> DECODE.
- DECODE (1 cycle), then IDLE:
  - 8'hE0: set ext_pending, no strobe.
  - 8'hF0: set brk_pending, no strobe.
  - other code C: key_strobe=1, key_extended=ext_pending, key_break=brk_pending, both same cycle as strobe; then clear pending flags.
  - Make: ps2_data_out<=C. Break: if C==ps2_data_out then ps2_data_out<=8'h00, else unchanged.
- key_extended/key_break valid only while key_strobe=1; 0 otherwise.
- Strobe latency: exactly 2 clk after the filtered falling edge of the stop bit.
- Timeout: in RECV, no falling edge for TIMEOUT_CYCLES consecutive clk -> frame_error pulse, -> IDLE, pending flags kept.
- Typematic repeats of same make code: strobe each time, ps2_data_out unchanged value.
- E0 F0 C sequence: one break event, key_extended=1, key_break=1.
- Repeated E0/F0 prefixes: flags stay set (idempotent).
- reset asserted mid-frame: immediate return to reset values; partial frame lost, no error pulse.
- Device-to-host direction only; ps2_clk/ps2_data never driven.

Optional Feature:
PS2_PARITY_CHECK_EN: defined -> odd-parity check in CHECK, bad parity drops the frame with frame_error. Undefined -> parity bit shifted but ignored; only stop bit validated.

Test Plan:
- Reset low 5 cycles, release -> all outputs 0, ps2_data_out=8'h00, no strobe.
- Frame 8'h43 (parity 0) -> one key_strobe 2 clk after stop, key_break=0, key_extended=0, ps2_data_out=8'h43 held.
- Frames F0 then 43 after make 43 -> strobe with key_break=1, ps2_data_out=8'h00; F0 alone produces no strobe.
- Frames E0, F0, 3B while ps2_data_out=8'h1C -> strobe with key_extended=1, key_break=1, ps2_data_out stays 8'h1C.
- Frame 8'h1C with parity 1 -> with PS2_PARITY_CHECK_EN: frame_error pulse, no strobe, ps2_data_out unchanged; without: strobe, ps2_data_out=8'h1C.
- Stop after 5 data bits for TIMEOUT_CYCLES, then send 8'h4B -> one frame_error pulse, then clean strobe with ps2_data_out=8'h4B; 2-cycle ps2_clk glitch mid-frame -> no extra bit sampled.
